// File: rtl/cgen_pipe_adder.sv
// Pipelined segmented carry-generate adder/subtractor.
//
// A WIDTH-bit add or subtract is split into NSEG = WIDTH/SEG segments, one per pipeline
// stage. Each stage resolves one SEG-bit slice with a generate/propagate carry chain and
// registers the segment carry-out for the next stage. This keeps the longest carry path
// at SEG bits regardless of WIDTH. Latency is NSEG cycles. A stall freezes the whole
// pipeline, including empty stages.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   in_valid, in_ready  operand handshake; in_ready = ~out_valid | out_ready
//   a, b, cin, sub      operands; sub=1 computes a-b (cin ignored), sub=0 computes a+b+cin
//   out_valid, out_ready result handshake
//   sum, cout, ovf      result mod 2^WIDTH, MSB carry-out (no-borrow in sub), signed overflow
module cgen_pipe_adder #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SEG   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSEG = WIDTH / SEG;

  logic adv;

  // Per-stage inputs: index s feeds stage s, index NSEG is the output stage register.
  // The word holds the unprocessed A bits at the bottom and finished sum bits at the top.
  logic [WIDTH-1:0] w_in [NSEG+1];
  logic [WIDTH-1:0] b_in [NSEG];
  logic             c_in [NSEG+1];
  logic             v_in [NSEG+1];

  // The whole pipeline moves in lock-step, so one enable serves every stage.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  assign w_in[0] = a;
  assign b_in[0] = b ^ {WIDTH{sub}};
  assign c_in[0] = sub | cin;
  assign v_in[0] = in_valid;

  for (genvar s = 0; s < NSEG; s++) begin : g_stage
    logic [SEG-1:0]   g;
    logic [SEG-1:0]   p;
    logic [SEG:0]     c;
    logic [WIDTH-1:0] seg_ext;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_q;
    logic             c_q;
    logic             v_q;

    assign g = w_in[s][SEG-1:0] & b_in[s][SEG-1:0];
    assign p = w_in[s][SEG-1:0] ^ b_in[s][SEG-1:0];

    always_comb begin
      c    = '0;
      c[0] = c_in[s];
      for (int i = 0; i < SEG; i++) begin
        c[i+1] = g[i] | (p[i] & c[i]);
      end
    end

    // Rotate right by one segment: the consumed A slice drops off the bottom and the new
    // sum slice enters at the top, so after NSEG stages the word is the sum in bit order.
    assign seg_ext = WIDTH'(p ^ c[SEG-1:0]);
    assign w_next  = (w_in[s] >> SEG) | (seg_ext << (WIDTH - SEG));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        w_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (adv) begin
        v_q <= v_in[s];
        // Data only moves with a real beat; bubbles leave the registers untouched.
        if (v_in[s]) begin
          w_q <= w_next;
          c_q <= c[SEG];
        end
      end
    end

    assign w_in[s+1] = w_q;
    assign c_in[s+1] = c_q;
    assign v_in[s+1] = v_q;

    if (s < NSEG - 1) begin : g_fwd
      // Remaining B' segments travel with the beat, shifted so the next slice is at bit 0.
      logic [WIDTH-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          b_q <= '0;
        end else if (adv && v_in[s]) begin
          b_q <= b_in[s] >> SEG;
        end
      end

      assign b_in[s+1] = b_q;
    end else begin : g_last
      logic ovf_q;

      // Signed overflow: carry into the MSB differs from carry out of the MSB.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv && v_in[s]) begin
          ovf_q <= c[SEG] ^ c[SEG-1];
        end
      end

      assign ovf = ovf_q;
    end
  end

  assign sum       = w_in[NSEG];
  assign cout      = c_in[NSEG];
  assign out_valid = v_in[NSEG];

endmodule

// File: tb/tb_cgen_pipe_adder.sv
module tb_cgen_pipe_adder;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned SEG   = 16;
  localparam int unsigned NSEG  = WIDTH / SEG;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              in_valid  = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  a         = '0;
  logic [WIDTH-1:0]  b         = '0;
  logic              cin       = 1'b0;
  logic              sub       = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic              ovf;

  cgen_pipe_adder #(
    .WIDTH(WIDTH),
    .SEG  (SEG)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
    int          stl;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   cyc       = 0;
  int   stall_cnt = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain wide arithmetic, signed overflow from operand/result signs.
  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y,
                                 input logic ci, input logic s);
    exp_t        e;
    logic [64:0] r;
    if (s) begin
      e.sum  = x - y;
      e.cout = (x >= y);
      e.ovf  = (x[63] != y[63]) && (e.sum[63] != x[63]);
    end else begin
      r      = {1'b0, x} + {1'b0, y} + 65'(ci);
      e.sum  = r[63:0];
      e.cout = r[64];
      e.ovf  = (x[63] == y[63]) && (e.sum[63] != x[63]);
    end
    e.cyc = 0;
    e.stl = 0;
    return e;
  endfunction

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = 64'h8000_0000_0000_0000;
      3:       v = 64'h7FFF_FFFF_FFFF_FFFF;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Input monitor: every accepted beat pushes its expected result.
  initial begin : in_mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && in_valid && in_ready) begin
        e     = model(a, b, cin, sub);
        e.cyc = cyc;
        e.stl = stall_cnt;
        sb_q.push_back(e);
      end
    end
  end

  // Output monitor: handshake rule, stall stability, in-order results and latency.
  initial begin : out_mon
    exp_t        e;
    logic        held;
    logic [63:0] h_sum;
    logic [1:0]  h_flags;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
        continue;
      end
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (held) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_sum", sum, h_sum);
        chk("stall_flags", {cout, ovf}, h_flags);
      end
      held = out_valid && !out_ready;
      if (held) begin
        stall_cnt++;
        h_sum   = sum;
        h_flags = {cout, ovf};
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got beat sum %h, expected no beat", sum);
        end else begin
          e = sb_q.pop_front();
          chk("sum", sum, e.sum);
          chk("cout", cout, e.cout);
          chk("ovf", ovf, e.ovf);
          chk("latency", cyc - e.cyc, NSEG + stall_cnt - e.stl);
        end
      end
    end
  end

  task automatic directed(input string nm, input logic [63:0] x, input logic [63:0] y,
                          input logic ci, input logic s,
                          input logic [63:0] es, input logic ec, input logic eo);
    int n;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    a         = x;
    b         = y;
    cin       = ci;
    sub       = s;
    out_ready = 1'b1;
    chk({nm, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    if (n > 10) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got no out_valid, expected one within 10 cycles", nm);
    end else begin
      chk({nm, "_latency"}, n, NSEG);
      chk({nm, "_sum"}, sum, es);
      chk({nm, "_cout"}, cout, ec);
      chk({nm, "_ovf"}, ovf, eo);
    end
  endtask

  task automatic drain(input string nm);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk({nm, "_drained"}, sb_q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic acc;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {cout, ovf}, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Directed cases
    directed("seg_carry", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0,
             64'h0000_0000_0001_0000, 1'b0, 1'b0);
    directed("full_chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0,
             64'h0, 1'b1, 1'b0);
    directed("sub_borrow", 64'd5, 64'd7, 1'b1, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    directed("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Streaming, back-to-back
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      a         = rnd64();
      b         = rnd64();
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = 1'b1;
      chk("stream_in_ready", in_ready, 1);
    end
    drain("stream");

    // Random backpressure; a pending beat is held until accepted
    acc      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 1) == 1);
        a        = rnd64();
        b        = rnd64();
        cin      = 1'($urandom_range(0, 1));
        sub      = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 9) < 3);
      @(negedge clk);
      acc = in_valid && in_ready;
    end
    drain("bp");

    // Async reset with one beat at the output and three in flight
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      a         = rnd64();
      b         = rnd64();
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_sum", sum, 0);
    sb_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale_beat", out_valid, 0);
    end
    directed("post_rst", 64'd1, 64'd1, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0);
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cgen_pipe_adder.md
Name: cgen_pipe_adder

Overview:
- Parametrised, pipelined successor to the combinational 64-bit carry-generate stage in the MDCLCG datapath.
- Splits a WIDTH-bit add/subtract into NSEG = WIDTH/SEG segments, one segment per pipeline stage.
- Registers the inter-segment carry between stages, so the LCG increment path closes timing at any width.
- Streaming valid/ready handshake with backpressure; one operation accepted per cycle when not stalled.

Parameters:
- WIDTH, 64, operand/result width; must be a multiple of SEG.
- SEG, 16, bits per pipeline segment; 1..WIDTH.
- NSEG, WIDTH/SEG (derived localparam), pipeline depth = latency in cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add mode only).
- sub  input  1  0 = A+B+cin, 1 = A-B (B inverted, carry-in forced 1, cin ignored).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of MSB; in sub mode 1 = no borrow (A >= B unsigned).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, out_valid, sum, cout, ovf and internal carry/operand registers clear to 0. After rst_n rises, in_ready = 1.
- Advance enable: adv = ~out_valid | out_ready. in_ready = adv, combinational, with no dependence on in_valid.
- Transfer rule: a beat is accepted when in_valid & in_ready. When adv = 0, every stage holds, including stages that are empty (no bubble collapsing).
- Stage 0 captures the full operands: b XOR {WIDTH{sub}}, the carry-in (sub ? 1 : cin) and a valid bit.
- Stage s (s = 0..NSEG-1):
  - Computes segment s from bits [s*SEG +: SEG], using the registered carry of stage s-1 (stage 0 uses the captured carry-in).
  - In-segment carries: g[i] = a[i]&b'[i], p[i] = a[i]^b'[i], c[i+1] = g[i] | p[i]&c[i], c[0] = segment carry-in.
  - Segment sum bit: p[i]^c[i].
- Registers per stage:
  - Completed low segments move forward with the beat (output deskew); not-yet-processed high operand segments also move forward (input skew).
  - Carry out of the segment is registered for the next stage.
- Latency: exactly NSEG cycles from acceptance to out_valid with no stall. Each stall cycle adds one cycle.
- Output flags: cout = carry out of bit WIDTH-1. ovf = carry into MSB XOR carry out of MSB. Both are registered with sum in the final stage.
- Throughput: 1 beat/cycle when out_ready is held high. Beats stay in order and are never dropped or duplicated.
- out_valid & ~out_ready: sum, cout and ovf stay stable until the handshake completes.
- NSEG = 1 (SEG = WIDTH): single-stage registered adder, latency 1; the same handshake rules apply.
- Wrap-around: the result is modulo 2^WIDTH, with no saturation.
- Reset mid-operation: in-flight beats are discarded and no partial result appears.
- Simultaneous acceptance on the input and consumption on the output in the same cycle is legal and is the normal streaming case.

Test Plan (WIDTH=64, SEG=16, latency 4):
- Reset then single add: a=0x0000_0000_0000_FFFF, b=1, cin=0 -> 4 cycles later sum=0x0000_0000_0001_0000, cout=0, ovf=0; the carry crosses the segment 0/1 boundary.
- Full-chain carry: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0; the carry ripples across all 4 stages.
- Subtract: sub=1, a=5, b=7 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0 (borrow). sub=1, a=0x8000_0000_0000_0000, b=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
- Streaming: 100 back-to-back random beats, out_ready=1 -> in_ready stays 1, results match the reference model in order, one per cycle after 4-cycle fill.
- Backpressure: random out_ready at 30% duty with random in_valid -> no loss or duplication, outputs stable while stalled, in_ready low exactly when out_valid & ~out_ready.
- Async reset mid-stream: rst_n pulsed low between clock edges with 3 beats in flight -> out_valid=0 immediately, no stale beat emitted after release; a new beat a=1, b=1 yields sum=2 after 4 cycles.
